// File: rtl/ob_mk_table_q.sv
// Ordered N-deep {uid, qty} resting table: head push/pop/update, tail insert, cancel by UID,
// plus a snapshot-based LANES-wide quantity query engine with a ready/valid handshake.
module ob_mk_table_q #(
    parameter int N     = 16,
    parameter int UID_W = 32,
    parameter int QTY_W = 16,
    parameter int LANES = 4,
    parameter int ACC_W = QTY_W + $clog2(N) + 1,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             head_push,
    input  logic [UID_W-1:0] head_push_uid,
    input  logic [QTY_W-1:0] head_push_qty,
    input  logic             head_pop,
    input  logic             head_upt,
    input  logic [QTY_W-1:0] head_upt_qty,
    input  logic             insert,
    input  logic [UID_W-1:0] insert_uid,
    input  logic [QTY_W-1:0] insert_qty,
    input  logic             cancel,
    input  logic [UID_W-1:0] cancel_uid,
    output logic             cancel_hit_w,
    output logic [QTY_W-1:0] cancel_hit_qty_w,
    output logic             evict_vld_r,
    output logic [UID_W-1:0] evict_uid_r,
    output logic             insert_drop_r,
    output logic             head_vld_r,
    output logic [UID_W-1:0] head_uid_r,
    output logic [QTY_W-1:0] head_qty_r,
    output logic [CNT_W-1:0] cnt_r,
    output logic             full_r,
    output logic             empty_r,
    input  logic             qry_vld,
    output logic             qry_rdy,
    output logic             qry_rsp_vld_r,
    output logic [ACC_W-1:0] qry_rsp_qty_r
);
    localparam int IDX_W = $clog2(N);
    localparam int NSUM  = N / LANES;
    localparam int SUM_W = (NSUM > 1) ? $clog2(NSUM) : 1;

    typedef enum logic [1:0] {Q_IDLE, Q_SUM, Q_RSP} q_state_t;

    // Slots at or beyond cnt_r are always held at zero.
    logic [UID_W-1:0] r_uid [N];
    logic [QTY_W-1:0] r_qty [N];
    logic [QTY_W-1:0] r_snap [N];
    logic [ACC_W-1:0] r_acc;
    logic [SUM_W-1:0] r_sum_idx;
    q_state_t         r_state;

    logic [UID_W-1:0] w_uid_nxt [N];
    logic [QTY_W-1:0] w_qty_nxt [N];
    logic [CNT_W-1:0] w_cnt_mid, w_cnt_nxt;
    logic             w_full, w_empty, w_pop_eff, w_pop_do, w_evict, w_drop;
    logic             w_hit_any, w_cancel_apply, w_upt_do;
    logic [IDX_W-1:0] w_hit_idx;
    logic [QTY_W-1:0] w_hit_qty;
    logic [ACC_W-1:0] w_lane_sum;

    assign w_full    = (cnt_r == CNT_W'(N));
    assign w_empty   = (cnt_r == '0);
    assign w_pop_eff = head_pop | (head_upt & (head_upt_qty == '0) & head_vld_r);
    assign w_pop_do  = w_pop_eff & ~w_empty & ~head_push;
    assign w_evict   = head_push & w_full;

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_idx = '0;
        w_hit_qty = '0;
        for (int i = 0; i < N; i++) begin
            if ((CNT_W'(i) < cnt_r) && (r_uid[i] == cancel_uid)) begin
                w_hit_any = 1'b1;
                w_hit_idx = IDX_W'(i);
                w_hit_qty = r_qty[i];
            end
        end
    end

    // Cancel only lands when no push or effective pop claims the structural slot.
    assign w_cancel_apply   = cancel & w_hit_any & ~head_push & ~w_pop_eff;
    assign w_upt_do         = head_upt & (head_upt_qty != '0) & head_vld_r & ~head_push &
                              ~w_pop_eff & ~(w_cancel_apply & (w_hit_idx == '0));
    assign cancel_hit_w     = w_cancel_apply;
    assign cancel_hit_qty_w = w_cancel_apply ? w_hit_qty : '0;

    always_comb begin
        w_uid_nxt = r_uid;
        w_qty_nxt = r_qty;
        w_cnt_mid = cnt_r;
        if (head_push) begin
            for (int i = 1; i < N; i++) begin
                w_uid_nxt[i] = r_uid[i-1];
                w_qty_nxt[i] = r_qty[i-1];
            end
            w_uid_nxt[0] = head_push_uid;
            w_qty_nxt[0] = head_push_qty;
            w_cnt_mid    = w_full ? cnt_r : cnt_r + CNT_W'(1);
        end else if (w_pop_do) begin
            for (int i = 0; i < N - 1; i++) begin
                w_uid_nxt[i] = r_uid[i+1];
                w_qty_nxt[i] = r_qty[i+1];
            end
            w_uid_nxt[N-1] = '0;
            w_qty_nxt[N-1] = '0;
            w_cnt_mid      = cnt_r - CNT_W'(1);
        end else begin
            if (w_cancel_apply) begin
                for (int i = 0; i < N - 1; i++) begin
                    if (IDX_W'(i) >= w_hit_idx) begin
                        w_uid_nxt[i] = r_uid[i+1];
                        w_qty_nxt[i] = r_qty[i+1];
                    end
                end
                w_uid_nxt[N-1] = '0;
                w_qty_nxt[N-1] = '0;
                w_cnt_mid      = cnt_r - CNT_W'(1);
            end
            if (w_upt_do) begin
                w_qty_nxt[0] = head_upt_qty;
            end
        end
        w_drop    = insert & (w_cnt_mid == CNT_W'(N));
        w_cnt_nxt = w_cnt_mid;
        if (insert && !w_drop) begin
            for (int i = 0; i < N; i++) begin
                if (CNT_W'(i) == w_cnt_mid) begin
                    w_uid_nxt[i] = insert_uid;
                    w_qty_nxt[i] = insert_qty;
                end
            end
            w_cnt_nxt = w_cnt_mid + CNT_W'(1);
        end
    end

    // Reset clears every output, empty_r included; it settles after the first clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_uid[i] <= '0;
                r_qty[i] <= '0;
            end
            cnt_r         <= '0;
            head_vld_r    <= 1'b0;
            head_uid_r    <= '0;
            head_qty_r    <= '0;
            full_r        <= 1'b0;
            empty_r       <= 1'b0;
            evict_vld_r   <= 1'b0;
            evict_uid_r   <= '0;
            insert_drop_r <= 1'b0;
        end else begin
            r_uid         <= w_uid_nxt;
            r_qty         <= w_qty_nxt;
            cnt_r         <= w_cnt_nxt;
            head_vld_r    <= (w_cnt_nxt != '0);
            head_uid_r    <= w_uid_nxt[0];
            head_qty_r    <= w_qty_nxt[0];
            full_r        <= (w_cnt_nxt == CNT_W'(N));
            empty_r       <= (w_cnt_nxt == '0);
            evict_vld_r   <= w_evict;
            evict_uid_r   <= w_evict ? r_uid[N-1] : '0;
            insert_drop_r <= w_drop;
        end
    end

    always_comb begin
        w_lane_sum = '0;
        for (int s = 0; s < NSUM; s++) begin
            if (SUM_W'(s) == r_sum_idx) begin
                for (int l = 0; l < LANES; l++) begin
                    w_lane_sum = w_lane_sum + ACC_W'(r_snap[s*LANES+l]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= Q_IDLE;
            qry_rdy       <= 1'b1;
            qry_rsp_vld_r <= 1'b0;
            qry_rsp_qty_r <= '0;
            r_acc         <= '0;
            r_sum_idx     <= '0;
            for (int i = 0; i < N; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            qry_rsp_vld_r <= 1'b0;
            case (r_state)
                Q_IDLE: begin
                    if (qry_vld) begin
                        for (int i = 0; i < N; i++) begin
                            r_snap[i] <= (CNT_W'(i) < cnt_r) ? r_qty[i] : '0;
                        end
                        r_acc     <= '0;
                        r_sum_idx <= '0;
                        qry_rdy   <= 1'b0;
                        r_state   <= Q_SUM;
                    end
                end
                Q_SUM: begin
                    r_acc     <= r_acc + w_lane_sum;
                    r_sum_idx <= r_sum_idx + SUM_W'(1);
                    if (r_sum_idx == SUM_W'(NSUM - 1)) begin
                        r_state <= Q_RSP;
                    end
                end
                Q_RSP: begin
                    qry_rsp_vld_r <= 1'b1;
                    qry_rsp_qty_r <= r_acc;
                    qry_rdy       <= 1'b1;
                    r_state       <= Q_IDLE;
                end
                default: begin
                    r_state <= Q_IDLE;
                    qry_rdy <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/ob_mk_table_q.md
Name: ob_mk_table_q

Overview:
- Parametrised successor to the market-order resting table: an ordered N-deep table of {uid, qty} entries.
- Slot 0 is the head; slot count-1 is the tail.
- Adds over the previous generation:
  - explicit field widths;
  - an occupancy counter;
  - tail eviction on push-when-full;
  - auto-removal of a head filled to zero;
  - a snapshot-based, LANES-wide multi-cycle quantity query with a ready/valid handshake.
- Sits between the match engine (head ops) and the command front-end (insert, cancel, query).

Parameters:
- N, 16, table depth (≥2).
- UID_W, 32, order UID width.
- QTY_W, 16, per-entry quantity width.
- LANES, 4, entries summed per query cycle; N mod LANES == 0.
- ACC_W, QTY_W+$clog2(N)+1, query accumulator width.
- CNT_W, $clog2(N+1), occupancy width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- head_push  in  1  push entry at head.
- head_push_uid  in  UID_W  pushed UID.
- head_push_qty  in  QTY_W  pushed quantity.
- head_pop  in  1  remove head.
- head_upt  in  1  rewrite head quantity.
- head_upt_qty  in  QTY_W  new head quantity.
- insert  in  1  append at tail.
- insert_uid  in  UID_W  appended UID.
- insert_qty  in  QTY_W  appended quantity.
- cancel  in  1  remove entry by UID.
- cancel_uid  in  UID_W  UID to cancel.
- cancel_hit_w  out  1  comb: cancel removed an entry this cycle.
- cancel_hit_qty_w  out  QTY_W  comb: quantity of removed entry (0 when no hit).
- evict_vld_r  out  1  tail evicted by push-when-full (1-cycle pulse).
- evict_uid_r  out  UID_W  evicted UID.
- insert_drop_r  out  1  insert discarded, table full (1-cycle pulse).
- head_vld_r  out  1  slot 0 valid.
- head_uid_r  out  UID_W  slot 0 UID.
- head_qty_r  out  QTY_W  slot 0 quantity.
- cnt_r  out  CNT_W  occupancy.
- full_r  out  1  cnt_r == N.
- empty_r  out  1  cnt_r == 0.
- qry_vld  in  1  query request.
- qry_rdy  out  1  query engine idle.
- qry_rsp_vld_r  out  1  query result valid (1-cycle pulse).
- qry_rsp_qty_r  out  ACC_W  sum of snapshot quantities.

Behaviour:
- Reset (async assert, sync deassert):
  - all slots invalid; all outputs 0;
  - qry_rdy = 1; FSM in IDLE.
- Table occupancy is always contiguous from slot 0.
- Effective pop: pop_eff = head_pop | (head_upt & head_upt_qty == 0 & head_vld_r).
- Structural op per cycle, by priority:
  - head_push: shift down. If full, the slot N-1 entry is lost and evict_vld_r/evict_uid_r pulse the next cycle.
  - pop_eff: shift up, ignored when empty.
  - cancel hit: entries after the hit shift up.
- Cancel:
  - Searched against the pre-cycle state; at most one match, UIDs are unique by contract.
  - cancel_hit_w = 1 only when removal is actually applied. A push or pop_eff in the same cycle suppresses it (cancel_hit_w = 0, table unchanged by cancel).
- head_upt with nonzero qty: writes slot 0 qty only if head_vld_r and no push/pop_eff this cycle; otherwise ignored.
- Insert:
  - Lands in the first free slot of the post-structural-op state.
  - If the post-op state is full: insert dropped, insert_drop_r pulses next cycle.
  - Insert into an empty table makes that entry head.
- Next-cycle counter update: cnt_r += push_applied_not_full + insert_applied − pop_applied − cancel_applied. Push when full leaves cnt unchanged.
- head_*, full_r and empty_r reflect the updated state one cycle after the op.
- Query FSM, IDLE → SUM → RSP → IDLE:
  - IDLE: qry_rdy = 1. qry_vld latches a snapshot of all N qty fields, with invalid slots forced to 0. The snapshot is taken from the pre-cycle state, so same-cycle ops are excluded. Clears acc; goes to SUM.
  - SUM: N/LANES cycles, adding LANES snapshot entries per cycle. No overflow is possible at ACC_W.
  - RSP: qry_rsp_vld_r = 1 for one cycle with qry_rsp_qty_r; then IDLE.
  - qry_rsp_qty_r holds its value until the next RSP.
  - Latency from the accepted qry_vld to qry_rsp_vld_r: N/LANES+1 cycles.
  - qry_vld while qry_rdy = 0 is ignored.
  - Table ops continue unaffected during a query.
- Reset asserted mid-query: FSM returns to IDLE and no response is issued.

Test Plan:
- Insert UIDs 1..4 with qty 10,20,30,40 → cnt_r = 4, head_uid_r = 1, head_qty_r = 10. Then query → response 100 after N/LANES+1 = 5 cycles; qry_rdy low for 5 cycles.
- Fill to N = 16, then head_push uid 99 → head_uid_r = 99, evict_vld_r pulse with the slot-15 UID, cnt_r stays 16. Insert next cycle → insert_drop_r pulse.
- Table 1..4, cancel uid 3 → cancel_hit_w = 1, cancel_hit_qty_w = 30, order becomes 1,2,4, cnt_r = 3. Cancel uid 3 + head_pop in the same cycle → cancel_hit_w = 0, only head removed.
- head_upt qty 0 on head uid 1 → entry removed, head_uid_r = 2. head_upt qty 5 → head_qty_r = 5. head_pop on empty → no change, cnt_r = 0.
- Query accepted, then pop + insert during SUM → response equals the sum at the accept cycle. Deassert rst_n during SUM → no qry_rsp_vld_r, all outputs 0, qry_rdy = 1.
